// File: rtl/bus_router.sv
// bus_router: single-master data-bus router that decodes each request against per-slave
// address windows, forwards it to one slave and completes unmapped or hung accesses with an error.
module bus_router #(
  parameter int unsigned                         NUM_SLAVES     = 3,
  parameter int unsigned                         ADDR_W         = 32,
  parameter int unsigned                         DATA_W         = 32,
  parameter logic [NUM_SLAVES-1:0][ADDR_W-1:0]   SLAVE_BASE     = '0,
  parameter logic [NUM_SLAVES-1:0][ADDR_W-1:0]   SLAVE_MASK     = '0,
  parameter int unsigned                         TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0]                   ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         m_valid_i,
  input  logic [ADDR_W-1:0]            m_addr_i,
  input  logic [DATA_W-1:0]            m_wdata_i,
  input  logic [(DATA_W/8)-1:0]        m_wstrb_i,
  output logic [DATA_W-1:0]            m_rdata_o,
  output logic                         m_ready_o,
  output logic [NUM_SLAVES-1:0]        s_valid_o,
  output logic [ADDR_W-1:0]            s_addr_o,
  output logic [DATA_W-1:0]            s_wdata_o,
  output logic [(DATA_W/8)-1:0]        s_wstrb_o,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata_i,
  input  logic [NUM_SLAVES-1:0]        s_ready_i,
  output logic                         err_o,
  output logic [ADDR_W-1:0]            err_addr_o,
  input  logic                         err_clr_i
);

  localparam int unsigned SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FORWARD = 2'd1,
    RESP    = 2'd2
  } state_t;

  state_t                 state_r, next_state_s;
  logic [SEL_W-1:0]       sel_r;
  logic [CNT_W-1:0]       cnt_r;
  logic                   hit_any_s;
  logic [SEL_W-1:0]       hit_sel_s;
  logic [NUM_SLAVES-1:0]  hit_onehot_s;
  logic                   sel_ready_s;
  logic [DATA_W-1:0]      sel_rdata_s;
  logic                   timeout_s;
  logic                   load_req_s;
  logic                   unmapped_s;
  logic                   fwd_ok_s;
  logic                   fwd_to_s;

  logic [DATA_W-1:0]      m_rdata_r;
  logic                   m_ready_r;
  logic [NUM_SLAVES-1:0]  s_valid_r;
  logic [ADDR_W-1:0]      s_addr_r;
  logic [DATA_W-1:0]      s_wdata_r;
  logic [(DATA_W/8)-1:0]  s_wstrb_r;
  logic                   err_r;
  logic [ADDR_W-1:0]      err_addr_r;

  // Address decode; scanning downward leaves the lowest-index hit selected.
  always_comb begin
    hit_any_s    = 1'b0;
    hit_sel_s    = '0;
    hit_onehot_s = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((m_addr_i & SLAVE_MASK[i]) == SLAVE_BASE[i]) begin
        hit_any_s = 1'b1;
        hit_sel_s = SEL_W'(i);
      end else begin
        hit_any_s = hit_any_s;
      end
    end
    for (int i = 0; i < NUM_SLAVES; i++) begin
      hit_onehot_s[i] = hit_any_s && (hit_sel_s == SEL_W'(i));
    end
  end

  // Response mux from the latched slave; other slaves' ready/data never reach the FSM.
  always_comb begin
    sel_ready_s = 1'b0;
    sel_rdata_s = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_r == SEL_W'(i)) begin
        sel_ready_s = s_ready_i[i];
        sel_rdata_s = s_rdata_i[i*DATA_W +: DATA_W];
      end else begin
        sel_ready_s = sel_ready_s;
      end
    end
    timeout_s = TIMEOUT_EN && (cnt_r == CNT_LAST);
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (m_valid_i) begin
          next_state_s = hit_any_s ? FORWARD : RESP;
        end else begin
          next_state_s = IDLE;
        end
      end
      FORWARD: begin
        if (sel_ready_s || timeout_s) begin
          next_state_s = RESP;
        end else begin
          next_state_s = FORWARD;
        end
      end
      RESP:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Per-state control strobes; ready beats a coincident timeout.
  always_comb begin
    load_req_s = 1'b0;
    unmapped_s = 1'b0;
    fwd_ok_s   = 1'b0;
    fwd_to_s   = 1'b0;
    case (state_r)
      IDLE: begin
        load_req_s = m_valid_i;
        unmapped_s = m_valid_i && !hit_any_s;
      end
      FORWARD: begin
        fwd_ok_s = sel_ready_s;
        fwd_to_s = !sel_ready_s && timeout_s;
      end
      RESP:    fwd_ok_s = 1'b0;
      default: fwd_ok_s = 1'b0;
    endcase
  end

  // Request capture and slave-side outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sel_r     <= '0;
      s_addr_r  <= '0;
      s_wdata_r <= '0;
      s_wstrb_r <= '0;
      s_valid_r <= '0;
    end else begin
      if (load_req_s) begin
        sel_r     <= hit_sel_s;
        s_addr_r  <= m_addr_i;
        s_wdata_r <= m_wdata_i;
        s_wstrb_r <= m_wstrb_i;
        s_valid_r <= hit_onehot_s;
      end else if (fwd_ok_s || fwd_to_s) begin
        s_valid_r <= '0;
      end
    end
  end

  // Master-side completion and wait counter; the counter only runs while forwarding.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m_ready_r <= 1'b0;
      m_rdata_r <= '0;
      cnt_r     <= '0;
    end else begin
      m_ready_r <= unmapped_s || fwd_ok_s || fwd_to_s;
      if (unmapped_s || fwd_to_s) begin
        m_rdata_r <= ERR_DATA;
      end else if (fwd_ok_s) begin
        m_rdata_r <= sel_rdata_s;
      end
      cnt_r <= (state_r == FORWARD) ? cnt_r + CNT_W'(1) : '0;
    end
  end

  // Sticky error flag; a new error outranks a simultaneous clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_r      <= 1'b0;
      err_addr_r <= '0;
    end else begin
      if (unmapped_s || fwd_to_s) begin
        err_r <= 1'b1;
      end else if (err_clr_i) begin
        err_r <= 1'b0;
      end
      if (unmapped_s) begin
        err_addr_r <= m_addr_i;
      end else if (fwd_to_s) begin
        err_addr_r <= s_addr_r;
      end
    end
  end

  assign m_rdata_o  = m_rdata_r;
  assign m_ready_o  = m_ready_r;
  assign s_valid_o  = s_valid_r;
  assign s_addr_o   = s_addr_r;
  assign s_wdata_o  = s_wdata_r;
  assign s_wstrb_o  = s_wstrb_r;
  assign err_o      = err_r;
  assign err_addr_o = err_addr_r;

endmodule
